// File: rtl/wishbone_nn_pkg.sv
// Shared definitions for the Wishbone side of the NN block.
//   wb_state_e  : initiator FSM states
//   WB_ADR_W    : default bus address width
//   WB_DAT_W    : default bus data width
//   NN_BASE_ADR : base byte address of the NN slave register window
package wishbone_nn_pkg;

    localparam int unsigned WB_ADR_W    = 32;
    localparam int unsigned WB_DAT_W    = 32;
    localparam logic [31:0] NN_BASE_ADR = 32'h3000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating cycle counter used to bound how long a bus cycle may wait for ACK.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset (count -> 0)
//   clear  : synchronous clear to 0, takes priority over enable
//   enable : increment by one (stops at TIMEOUT, never wraps)
//   hit    : high while count == TIMEOUT-1
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign hit = (count == CNT_LAST);

endmodule

// File: rtl/wishbone_nn_master.sv
// Wishbone classic single-transfer initiator.
// Takes one command on a valid/ready port, runs one CYC/STB cycle, waits for ACK
// (bounded by TIMEOUT cycles) and returns read data or an error on a valid/ready
// response port. Every output comes straight from a flop.
//   wb_clk_i, wb_rst_i          : clock, async active-high reset
//   cmd_valid_i/cmd_ready_o     : command handshake
//   cmd_we_i/adr/dat/sel        : command fields
//   rsp_valid_o/rsp_ready_i     : response handshake
//   rsp_dat_o, rsp_err_o        : read data (0 for writes/errors), timeout flag
//   wbm_*                       : Wishbone master port
module wishbone_nn_master
    import wishbone_nn_pkg::*;
#(
    parameter int unsigned ADR_W   = WB_ADR_W,
    parameter int unsigned DAT_W   = WB_DAT_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_we_i,
    input  logic [ADR_W-1:0]   cmd_adr_i,
    input  logic [DAT_W-1:0]   cmd_dat_i,
    input  logic [DAT_W/8-1:0] cmd_sel_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DAT_W-1:0]   rsp_dat_o,
    output logic               rsp_err_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [ADR_W-1:0]   wbm_adr_o,
    output logic [DAT_W-1:0]   wbm_dat_o,
    output logic [DAT_W/8-1:0] wbm_sel_o,
    input  logic [DAT_W-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i
);

    localparam int unsigned SEL_W = DAT_W / 8;

    wb_state_e        state_q, state_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;

    logic ctr_clear;
    logic ctr_enable;
    logic ctr_hit;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clear  (ctr_clear),
        .enable (ctr_enable),
        .hit    (ctr_hit)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        ctr_clear   = 1'b0;
        ctr_enable  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // cmd_ready_q is low for the first cycle after reset, so gate on it
                if (cmd_valid_i && cmd_ready_q) begin
                    we_d      = cmd_we_i;
                    adr_d     = cmd_adr_i;
                    dat_d     = cmd_dat_i;
                    sel_d     = cmd_sel_i;
                    cyc_d     = 1'b1;
                    ctr_clear = 1'b1;
                    state_d   = BUS;
                end
            end
            BUS: begin
                // ACK has priority over a simultaneous timeout
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (ctr_hit) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    ctr_enable = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;

endmodule

// File: tb/tb_wishbone_nn_master.sv
// Directed bench for wishbone_nn_master (TIMEOUT=8). The bench plays the slave,
// pushes the expected response of each command into a queue when it is issued and
// pops/compares it when rsp_valid_o appears.
module tb_wishbone_nn_master;
    import wishbone_nn_pkg::*;

    localparam int unsigned ADR_W   = 32;
    localparam int unsigned DAT_W   = 32;
    localparam int unsigned SEL_W   = DAT_W / 8;
    localparam int unsigned TIMEOUT = 8;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_i;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic             cmd_we_i;
    logic [ADR_W-1:0] cmd_adr_i;
    logic [DAT_W-1:0] cmd_dat_i;
    logic [SEL_W-1:0] cmd_sel_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [DAT_W-1:0] rsp_dat_o;
    logic             rsp_err_o;
    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [ADR_W-1:0] wbm_adr_o;
    logic [DAT_W-1:0] wbm_dat_o;
    logic [SEL_W-1:0] wbm_sel_o;
    logic [DAT_W-1:0] wbm_dat_i;
    logic             wbm_ack_i;

    wishbone_nn_master #(
        .ADR_W   (ADR_W),
        .DAT_W   (DAT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .cmd_sel_i   (cmd_sel_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int compared   = 0;
    int mismatched = 0;

    // {err, dat}
    logic [DAT_W:0] exp_q[$];

    task automatic check(input string name, input string what,
                         input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s.%s: observed %0h expected %0h", name, what, obs, exp);
        end
    endtask

    // Issue one command at the current negedge. The slave asserts ACK so that it is
    // sampled on the ack_cyc-th edge of STB being high (ack_cyc > TIMEOUT = never).
    // The response is then held for 'hold' cycles; with 'pend' set, a new command is
    // offered during the hold and must not be accepted.
    task automatic run_cmd(input string name, input logic we, input logic [ADR_W-1:0] adr,
                           input logic [DAT_W-1:0] dat, input logic [SEL_W-1:0] sel,
                           input int ack_cyc, input logic [DAT_W-1:0] ack_dat,
                           input int hold, input logic pend);
        int             stb_cnt;
        logic           exp_err;
        logic [DAT_W:0] e;
        exp_err = (ack_cyc > int'(TIMEOUT));
        check(name, "cmd_ready", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        cmd_sel_i   = sel;
        exp_q.push_back({exp_err, (we || exp_err) ? {DAT_W{1'b0}} : ack_dat});
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        check(name, "stb", wbm_stb_o, 1);
        check(name, "cyc", wbm_cyc_o, 1);
        check(name, "ready_busy", cmd_ready_o, 0);
        check(name, "wbm_fields", {wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o},
              {we, adr, dat, sel});
        stb_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!wbm_stb_o) break;
            stb_cnt++;
            wbm_ack_i = (stb_cnt == ack_cyc);
            wbm_dat_i = (stb_cnt == ack_cyc) ? ack_dat : DAT_W'($urandom);
            @(negedge wb_clk_i);
        end
        wbm_ack_i = 1'b0;
        check(name, "stb_len", stb_cnt, exp_err ? TIMEOUT : ack_cyc);
        check(name, "rsp_valid", rsp_valid_o, 1);
        e = exp_q.pop_front();
        check(name, "rsp_dat", rsp_dat_o, e[DAT_W-1:0]);
        check(name, "rsp_err", rsp_err_o, e[DAT_W]);
        for (int k = 0; k < hold; k++) begin
            // ACK outside BUS and changing slave data must not disturb the response
            wbm_ack_i = (k == 0);
            wbm_dat_i = DAT_W'($urandom);
            if (pend) begin
                cmd_valid_i = 1'b1;
                cmd_adr_i   = NN_BASE_ADR + 32'h100;
            end
            @(negedge wb_clk_i);
            check(name, "hold_valid", rsp_valid_o, 1);
            check(name, "hold_rsp", {rsp_err_o, rsp_dat_o}, e);
            check(name, "hold_ready", cmd_ready_o, 0);
            check(name, "hold_stb", wbm_stb_o, 0);
        end
        wbm_ack_i   = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready_i = 1'b0;
        check(name, "rsp_done", rsp_valid_o, 0);
        check(name, "idle_ready", cmd_ready_o, 1);
        check(name, "idle_stb", wbm_stb_o, 0);
        check(name, "adr_kept", wbm_adr_o, adr);
    endtask

    initial begin
        wb_rst_i    = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        cmd_sel_i   = '0;
        rsp_ready_i = 1'b0;
        wbm_dat_i   = '0;
        wbm_ack_i   = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        check("reset", "outputs",
              {cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o},
              '0);
        check("reset", "wbm_bus", {wbm_adr_o, wbm_sel_o}, '0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // 1: write, ACK sampled on the 3rd STB edge
        run_cmd("wr", 1'b1, NN_BASE_ADR, 32'hDEAD_BEEF, 4'hF, 3, 32'h5555_AAAA, 0, 1'b0);
        // 2: read with immediate ACK
        run_cmd("rd", 1'b0, NN_BASE_ADR + 32'h4, '0, 4'hF, 1, 32'h1234_5678, 0, 1'b0);
        // 3: read that never gets ACK
        run_cmd("timeout", 1'b0, NN_BASE_ADR + 32'h8, '0, 4'h3, 100, 32'h0, 1, 1'b0);
        // 4: ACK on the same edge the timeout would fire
        run_cmd("ack_at_limit", 1'b0, NN_BASE_ADR + 32'hC, '0, 4'hF, TIMEOUT, 32'hCAFE_F00D,
                0, 1'b0);
        // 5: response back-pressure with a competing command offered meanwhile
        run_cmd("backpress", 1'b1, NN_BASE_ADR + 32'h10, 32'h0BAD_F00D, 4'h1, 2, 32'h0, 5, 1'b1);
        run_cmd("after_bp", 1'b0, NN_BASE_ADR + 32'h14, '0, 4'hF, 1, 32'h8765_4321, 0, 1'b0);

        // 6: reset while STB is high
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = NN_BASE_ADR + 32'h18;
        cmd_sel_i   = 4'hF;
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        check("rst_mid", "stb_up", wbm_stb_o, 1);
        @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b1;
        #1;
        check("rst_mid", "stb_drop", {wbm_cyc_o, wbm_stb_o}, 0);
        check("rst_mid", "no_rsp", rsp_valid_o, 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("rst_mid", "idle", {cmd_ready_o, rsp_valid_o, wbm_stb_o}, 3'b100);
        run_cmd("post_rst", 1'b0, NN_BASE_ADR + 32'h1C, '0, 4'hF, 2, 32'hA5A5_0F0F, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
